// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// master = producer/consumer side, slave = adder side.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: one 4-bit carry-lookahead slice, one nibble per clock.
// Carry is registered between nibbles; valid/ready on both sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [3:0] w_an;
    logic [3:0] w_bn;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic [3:0] w_s;

    // Current nibble slice: generate/propagate lookahead carries and sum bits.
    always_comb begin
        w_an   = r_a[r_idx*4 +: 4];
        w_bn   = r_b[r_idx*4 +: 4];
        w_g    = w_an & w_bn;
        w_p    = w_an | w_bn;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_s    = w_an ^ w_bn ^ w_c[3:0];
    end

    // Control FSM with datapath registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*4 +: 4] <= w_s;
                    r_carry             <= w_c[4];
                    if (r_idx == LAST) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder, WIDTH=16 and WIDTH=4 instances.
// Expected values are hand-computed constants.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to measure acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_if #(.WIDTH(16)) m16 ();
    nibble_serial_adder_if #(.WIDTH(4))  m4 ();

    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (m16.slave)
    );

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (m4.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (!m16.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!m16.out_valid) chk("w16_timeout", 32'(m16.out_valid), 1);
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
        m16.a        = a;
        m16.b        = b;
        m16.cin      = cin;
        m16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m16.in_valid = 1'b0;
    endtask

    task automatic release16();
        m16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m16.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        int hits;

        m16.in_valid  = 1'b0;
        m16.a         = '0;
        m16.b         = '0;
        m16.cin       = 1'b0;
        m16.out_ready = 1'b0;
        m4.in_valid   = 1'b0;
        m4.a          = '0;
        m4.b          = '0;
        m4.cin        = 1'b0;
        m4.out_ready  = 1'b0;

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(m16.in_ready), 1);
        chk("rst_out_valid", 32'(m16.out_valid), 0);
        chk("rst_sum", 32'(m16.sum), 0);
        chk("rst_cout", 32'(m16.cout), 0);

        // Full carry ripple across every nibble.
        start16(16'hFFFF, 16'h0001, 1'b0);
        chk("t1_busy", 32'(m16.in_ready), 0);
        wait16(n);
        chk("t1_latency", 32'(n), 4);
        chk("t1_sum", 32'(m16.sum), 32'h0000);
        chk("t1_cout", 32'(m16.cout), 1);
        release16();
        chk("t1_ov_low", 32'(m16.out_valid), 0);
        chk("t1_idle", 32'(m16.in_ready), 1);

        // Operands changed during RUN must not affect the result.
        start16(16'h1234, 16'h4321, 1'b1);
        m16.a   = 16'hAAAA;
        m16.b   = 16'hAAAA;
        m16.cin = 1'b0;
        @(posedge clk);
        #1;
        chk("t2_partial", 32'(m16.sum), 32'h0006);
        wait16(n);
        chk("t2_latency", 32'(n), 3);
        chk("t2_sum", 32'(m16.sum), 32'h5556);
        chk("t2_cout", 32'(m16.cout), 0);
        release16();

        // Backpressure with in_valid asserted during DONE.
        start16(16'h8000, 16'h8000, 1'b0);
        wait16(n);
        m16.a        = 16'h0001;
        m16.b        = 16'h0001;
        m16.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("t3_ov_hold", 32'(m16.out_valid), 1);
            chk("t3_in_ready", 32'(m16.in_ready), 0);
            chk("t3_sum", 32'(m16.sum), 32'h0000);
            chk("t3_cout", 32'(m16.cout), 1);
        end
        m16.in_valid = 1'b0;
        release16();
        chk("t3_idle", 32'(m16.in_ready), 1);
        chk("t3_ov_low", 32'(m16.out_valid), 0);

        // Reset in the middle of RUN discards the operation.
        start16(16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t4_mid_busy", 32'(m16.in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_idle", 32'(m16.in_ready), 1);
        chk("t4_ov", 32'(m16.out_valid), 0);
        chk("t4_sum", 32'(m16.sum), 0);
        chk("t4_cout", 32'(m16.cout), 0);
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (m16.out_valid) hits++;
        end
        chk("t4_no_result", 32'(hits), 0);

        // Back-to-back with in_valid and out_ready held high.
        m16.a         = 16'h0F0F;
        m16.b         = 16'h0101;
        m16.cin       = 1'b0;
        m16.in_valid  = 1'b1;
        m16.out_ready = 1'b1;
        @(posedge clk);
        t0 = cyc;
        #1;
        m16.a   = 16'hFFFF;
        m16.b   = 16'hFFFF;
        m16.cin = 1'b1;
        wait16(n);
        chk("t5a_latency", 32'(n), 4);
        chk("t5a_sum", 32'(m16.sum), 32'h1010);
        chk("t5a_cout", 32'(m16.cout), 0);
        @(posedge clk);
        #1;
        chk("t5_idle", 32'(m16.in_ready), 1);
        @(posedge clk);
        t1 = cyc;
        #1;
        m16.in_valid = 1'b0;
        chk("t5_accept_busy", 32'(m16.in_ready), 0);
        chk("t5_spacing", 32'(t1 - t0), 6);
        wait16(n);
        chk("t5b_latency", 32'(n), 4);
        chk("t5b_sum", 32'(m16.sum), 32'hFFFF);
        chk("t5b_cout", 32'(m16.cout), 1);
        @(posedge clk);
        #1;
        m16.out_ready = 1'b0;
        chk("t5b_idle", 32'(m16.in_ready), 1);

        // WIDTH=4: RUN is a single edge.
        m4.a        = 4'h9;
        m4.b        = 4'h8;
        m4.cin      = 1'b1;
        m4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m4.in_valid = 1'b0;
        chk("w4_ov_early", 32'(m4.out_valid), 0);
        @(posedge clk);
        #1;
        chk("w4_ov", 32'(m4.out_valid), 1);
        chk("w4_sum", 32'(m4.sum), 32'h2);
        chk("w4_cout", 32'(m4.cout), 1);
        m4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m4.out_ready = 1'b0;
        chk("w4_idle", 32'(m4.in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
